// File: rtl/wb_lsu_if.sv
// ---------------------------------------------------------------------------
// wb_lsu_if -- bundle of every non-clock signal of the wb_lsu load/store unit.
//
// Signal groups (names keep the LSU-side direction suffix):
//   request   : req_valid_i, req_ready_o, req_we_i, req_addr_i, req_size_i,
//               req_unsigned_i, req_wdata_i
//   response  : rsp_valid_o, rsp_ready_i, rsp_rdata_o, rsp_err_o,
//               rsp_misaligned_o
//   wishbone  : cyc_o, stb_o, we_o, adr_o, sel_o, dat_o, dat_i,
//               ack_i, err_i, rty_i
//
// Modports:
//   master : the LSU itself (drives *_o, samples *_i)
//   slave  : the environment around the LSU (requester, responder, bus slave)
// ---------------------------------------------------------------------------
interface wb_lsu_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    // request channel
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [ADDR_W-1:0]     req_addr_i;
    logic [1:0]            req_size_i;
    logic                  req_unsigned_i;
    logic [DATA_W-1:0]     req_wdata_i;

    // response channel
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_W-1:0]     rsp_rdata_o;
    logic                  rsp_err_o;
    logic                  rsp_misaligned_o;

    // wishbone classic master side
    logic                  cyc_o;
    logic                  stb_o;
    logic                  we_o;
    logic [ADDR_W-1:0]     adr_o;
    logic [DATA_W/8-1:0]   sel_o;
    logic [DATA_W-1:0]     dat_o;
    logic [DATA_W-1:0]     dat_i;
    logic                  ack_i;
    logic                  err_i;
    logic                  rty_i;

    modport master (
        input  req_valid_i, req_we_i, req_addr_i, req_size_i,
               req_unsigned_i, req_wdata_i, rsp_ready_i,
               dat_i, ack_i, err_i, rty_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
               rsp_misaligned_o, cyc_o, stb_o, we_o, adr_o, sel_o, dat_o
    );

    modport slave (
        output req_valid_i, req_we_i, req_addr_i, req_size_i,
               req_unsigned_i, req_wdata_i, rsp_ready_i,
               dat_i, ack_i, err_i, rty_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
               rsp_misaligned_o, cyc_o, stb_o, we_o, adr_o, sel_o, dat_o
    );
endinterface

// File: rtl/wb_lsu.sv
// ---------------------------------------------------------------------------
// wb_lsu -- single-outstanding load/store unit with a Wishbone classic master.
//
// Accepts one request at a time, checks alignment, runs one Wishbone cycle
// (reissued after a one-cycle gap on rty_i, up to MAX_RETRY times), and hands
// back a response holding sign/zero-extended load data or an error flag.
//
// Ports:
//   clk_i  : clock, all state on the rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : wb_lsu_if.master -- request, response and Wishbone signals
//
// Parameters:
//   DATA_W         : data bus width, 32 or 64
//   ADDR_W         : byte address width
//   MAX_RETRY      : rty_i reissues allowed before the request fails
//   TIMEOUT_CYCLES : longest wait for a termination in one bus cycle
//
// Optional feature:
//   WB_LSU_TIMEOUT_EN -- when defined, a per-bus-cycle watchdog ends a cycle
//   with an error after TIMEOUT_CYCLES cycles; otherwise the bus waits forever.
// ---------------------------------------------------------------------------
module wb_lsu #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int MAX_RETRY      = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    wb_lsu_if.master  bus
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        GAP  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    // captured request attributes needed after acceptance
    logic             we_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic [OFF_W-1:0] lane_q;
    logic [RTY_W-1:0] retry_cnt;

    // registered outputs
    logic              ready_q;
    logic              cyc_q;
    logic              bus_we_q;
    logic [ADDR_W-1:0] adr_q;
    logic [NB-1:0]     sel_q;
    logic [DATA_W-1:0] dat_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic              rsp_mis_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    // next values of the registered outputs
    logic              ready_d;
    logic              cyc_d;
    logic              bus_we_d;
    logic              rsp_valid_d;
    logic              rsp_err_d;
    logic              rsp_mis_d;
    logic [DATA_W-1:0] rsp_rdata_d;

    // request decode
    logic              accept;
    logic [OFF_W-1:0]  req_lane;
    logic [OFF_W-1:0]  align_mask;
    logic [NB-1:0]     size_sel;
    logic              req_misaligned;
    logic [NB-1:0]     req_sel;
    logic [DATA_W-1:0] req_dat;
    logic [ADDR_W-1:0] req_adr;

    // load data extraction
    logic [DATA_W-1:0] lane_data;
    logic [DATA_W-1:0] keep_mask;
    logic              sign_bit;
    logic [DATA_W-1:0] load_data;

    logic retry_ok;
    logic tmo_expire;

    assign accept   = (state == IDLE) && ready_q && bus.req_valid_i;
    assign req_lane = bus.req_addr_i[OFF_W-1:0];
    assign req_adr  = {bus.req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign req_sel  = size_sel << req_lane;
    assign req_dat  = bus.req_wdata_i << {req_lane, 3'b000};
    assign retry_ok = (retry_cnt < RTY_W'(MAX_RETRY));

    // Alignment check: the low address bits covered by the access size must be
    // zero, and a dword access can never fit on a 32-bit bus.
    always_comb begin
        align_mask = '0;
        size_sel   = '0;
        case (bus.req_size_i)
            2'd0: begin align_mask = OFF_W'(0); size_sel = NB'(8'h01); end
            2'd1: begin align_mask = OFF_W'(1); size_sel = NB'(8'h03); end
            2'd2: begin align_mask = OFF_W'(3); size_sel = NB'(8'h0F); end
            default: begin align_mask = OFF_W'(7); size_sel = NB'(8'hFF); end
        endcase
        req_misaligned = ((req_lane & align_mask) != '0) ||
                         ((bus.req_size_i == 2'd3) && (DATA_W == 32));
    end

    // Load extraction: shift the addressed lane down to bit 0, keep the bits
    // that belong to the access size and fill the rest with the sign or zeros.
    always_comb begin
        lane_data = bus.dat_i >> {lane_q, 3'b000};
        keep_mask = '1;
        sign_bit  = lane_data[DATA_W-1];
        case (size_q)
            2'd0: begin keep_mask = DATA_W'(8'hFF);          sign_bit = lane_data[7];  end
            2'd1: begin keep_mask = DATA_W'(16'hFFFF);       sign_bit = lane_data[15]; end
            2'd2: begin keep_mask = DATA_W'(32'hFFFF_FFFF);  sign_bit = lane_data[31]; end
            default: begin keep_mask = '1;                   sign_bit = lane_data[DATA_W-1]; end
        endcase
        load_data = (lane_data & keep_mask) |
                    ((sign_bit && !uns_q) ? ~keep_mask : '0);
    end

`ifdef WB_LSU_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Counts cycles spent in BUS; restarts on acceptance and during each GAP
    // so every reissued bus cycle gets the full budget.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt <= '0;
        end else if (accept || (state == GAP)) begin
            tmo_cnt <= '0;
        end else if (state == BUS) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    assign tmo_expire = (state == BUS) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_expire = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Terminations rank err > ack > rty; the timeout only
    // fires when nothing terminated the cycle on the same edge.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = req_misaligned ? RESP : BUS;
                end
            end
            BUS: begin
                if (bus.err_i || bus.ack_i) begin
                    next_state = RESP;
                end else if (bus.rty_i) begin
                    next_state = retry_ok ? GAP : RESP;
                end else if (tmo_expire) begin
                    next_state = RESP;
                end
            end
            GAP: begin
                next_state = BUS;
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output logic: next values for every registered output. The response
    // fields are loaded once on entry to RESP and held until the handshake.
    always_comb begin
        ready_d     = (next_state == IDLE);
        cyc_d       = (next_state == BUS);
        bus_we_d    = (next_state == BUS) && (accept ? bus.req_we_i : we_q);
        rsp_valid_d = (next_state == RESP);
        rsp_err_d   = rsp_err_q;
        rsp_mis_d   = rsp_mis_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    rsp_err_d   = 1'b0;
                    rsp_mis_d   = req_misaligned;
                    rsp_rdata_d = '0;
                end
            end
            BUS: begin
                if (next_state == RESP) begin
                    // anything other than a clean ack is an error
                    rsp_err_d   = bus.err_i || !bus.ack_i;
                    rsp_mis_d   = 1'b0;
                    rsp_rdata_d = (bus.ack_i && !bus.err_i && !we_q) ? load_data : '0;
                end
            end
            RESP: begin
                if (next_state == IDLE) begin
                    rsp_err_d   = 1'b0;
                    rsp_mis_d   = 1'b0;
                    rsp_rdata_d = '0;
                end
            end
            default: begin
            end
        endcase
    end

    // Output registers. Address, select and write data are loaded only for an
    // aligned request and then held untouched through retries.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_q     <= 1'b0;
            cyc_q       <= 1'b0;
            bus_we_q    <= 1'b0;
            adr_q       <= '0;
            sel_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_mis_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            ready_q     <= ready_d;
            cyc_q       <= cyc_d;
            bus_we_q    <= bus_we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_mis_q   <= rsp_mis_d;
            rsp_rdata_q <= rsp_rdata_d;
            if (accept && !req_misaligned) begin
                adr_q <= req_adr;
                sel_q <= req_sel;
                dat_q <= req_dat;
            end
        end
    end

    // Request attributes and the retry counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q      <= 1'b0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            lane_q    <= '0;
            retry_cnt <= '0;
        end else if (accept) begin
            we_q      <= bus.req_we_i;
            size_q    <= bus.req_size_i;
            uns_q     <= bus.req_unsigned_i;
            lane_q    <= req_lane;
            retry_cnt <= '0;
        end else if ((state == BUS) && bus.rty_i && !bus.ack_i && !bus.err_i && retry_ok) begin
            retry_cnt <= retry_cnt + RTY_W'(1);
        end
    end

    assign bus.req_ready_o      = ready_q;
    assign bus.cyc_o            = cyc_q;
    assign bus.stb_o            = cyc_q;
    assign bus.we_o             = bus_we_q;
    assign bus.adr_o            = adr_q;
    assign bus.sel_o            = sel_q;
    assign bus.dat_o            = dat_q;
    assign bus.rsp_valid_o      = rsp_valid_q;
    assign bus.rsp_err_o        = rsp_err_q;
    assign bus.rsp_misaligned_o = rsp_mis_q;
    assign bus.rsp_rdata_o      = rsp_rdata_q;

endmodule

// File: tb/tb_wb_lsu.sv
// ---------------------------------------------------------------------------
// tb_wb_lsu -- directed self-checking bench for wb_lsu (DATA_W=32).
// Expected responses are queued when a request is driven and popped when the
// LSU presents a response. Inputs change and outputs are sampled on the
// falling clock edge. With WB_LSU_TIMEOUT_EN defined the watchdog is exercised,
// otherwise the indefinite wait is.
// ---------------------------------------------------------------------------
module tb_wb_lsu;

    localparam int DATA_W         = 32;
    localparam int ADDR_W         = 32;
    localparam int MAX_RETRY      = 3;
    localparam int TIMEOUT_CYCLES = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    wb_lsu_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

    wb_lsu #(
        .DATA_W        (DATA_W),
        .ADDR_W        (ADDR_W),
        .MAX_RETRY     (MAX_RETRY),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus_if)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        mis;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bound_expired(input string tag);
        checks++;
        errors++;
        $display("[TB] FAIL %s observed=no-event expected=event-within-bound", tag);
    endtask

    // Drive one request at a falling edge once req_ready_o is up; returns at
    // the falling edge just after the accepting rising edge.
    task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                  input logic uns, input logic [31:0] wdata, input logic track,
                                  input logic [31:0] exp_rdata, input logic exp_err, input logic exp_mis);
        int   n;
        rsp_t e;
        n = 0;
        while (bus_if.req_ready_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (bus_if.req_ready_o !== 1'b1) begin
            bound_expired("req_ready");
            return;
        end
        bus_if.req_valid_i    = 1'b1;
        bus_if.req_we_i       = we;
        bus_if.req_addr_i     = addr;
        bus_if.req_size_i     = size;
        bus_if.req_unsigned_i = uns;
        bus_if.req_wdata_i    = wdata;
        if (track) begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.mis   = exp_mis;
            exp_q.push_back(e);
        end
        tick();
        bus_if.req_valid_i = 1'b0;
    endtask

    // Wait for a response, compare it with the head of the scoreboard for
    // hold+1 cycles with rsp_ready_i low, then complete the handshake.
    task automatic wait_response(input string tag, input int hold);
        int   n;
        rsp_t e;
        n = 0;
        while (bus_if.rsp_valid_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (bus_if.rsp_valid_o !== 1'b1) begin
            bound_expired({tag, "_rsp_valid"});
            return;
        end
        if (exp_q.size() == 0) begin
            bound_expired({tag, "_scoreboard"});
            return;
        end
        e = exp_q.pop_front();
        for (int h = 0; h <= hold; h++) begin
            check_output({tag, "_rdata"}, bus_if.rsp_rdata_o, e.rdata);
            check_output({tag, "_err"}, 32'(bus_if.rsp_err_o), 32'(e.err));
            check_output({tag, "_mis"}, 32'(bus_if.rsp_misaligned_o), 32'(e.mis));
            check_output({tag, "_valid"}, 32'(bus_if.rsp_valid_o), 32'd1);
            if (h < hold) tick();
        end
        bus_if.rsp_ready_i = 1'b1;
        tick();
        bus_if.rsp_ready_i = 1'b0;
        check_output({tag, "_valid_drop"}, 32'(bus_if.rsp_valid_o), 32'd0);
    endtask

    task automatic ack_with(input logic [31:0] data);
        bus_if.dat_i = data;
        bus_if.ack_i = 1'b1;
        tick();
        bus_if.ack_i = 1'b0;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog observed=stuck expected=finish");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    initial begin
        int n;

        bus_if.req_valid_i    = 1'b0;
        bus_if.req_we_i       = 1'b0;
        bus_if.req_addr_i     = '0;
        bus_if.req_size_i     = '0;
        bus_if.req_unsigned_i = 1'b0;
        bus_if.req_wdata_i    = '0;
        bus_if.rsp_ready_i    = 1'b0;
        bus_if.dat_i          = '0;
        bus_if.ack_i          = 1'b0;
        bus_if.err_i          = 1'b0;
        bus_if.rty_i          = 1'b0;

        #1 rst_n = 1'b0;
        repeat (3) tick();

        // reset values
        check_output("rst_cyc",       32'(bus_if.cyc_o), 32'd0);
        check_output("rst_stb",       32'(bus_if.stb_o), 32'd0);
        check_output("rst_we",        32'(bus_if.we_o), 32'd0);
        check_output("rst_adr",       bus_if.adr_o, 32'd0);
        check_output("rst_sel",       32'(bus_if.sel_o), 32'd0);
        check_output("rst_dat",       bus_if.dat_o, 32'd0);
        check_output("rst_rsp_valid", 32'(bus_if.rsp_valid_o), 32'd0);
        check_output("rst_rsp_err",   32'(bus_if.rsp_err_o), 32'd0);
        check_output("rst_rsp_mis",   32'(bus_if.rsp_misaligned_o), 32'd0);
        check_output("rst_rsp_rdata", bus_if.rsp_rdata_o, 32'd0);
        check_output("rst_req_ready", 32'(bus_if.req_ready_o), 32'd0);

        rst_n = 1'b1;
        tick();
        tick();

        $display("[TB] signed byte load from 0x1003");
        apply_stimulus(1'b0, 32'h0000_1003, 2'd0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b0);
        check_output("ldb_cyc", 32'(bus_if.cyc_o), 32'd1);
        check_output("ldb_stb", 32'(bus_if.stb_o), 32'd1);
        check_output("ldb_we",  32'(bus_if.we_o), 32'd0);
        check_output("ldb_adr", bus_if.adr_o, 32'h0000_1000);
        check_output("ldb_sel", 32'(bus_if.sel_o), 32'h8);
        ack_with(32'h80FF_FFFF);
        check_output("ldb_cyc_drop", 32'(bus_if.cyc_o), 32'd0);
        wait_response("ldb_s", 0);

        $display("[TB] unsigned byte load from 0x1003");
        apply_stimulus(1'b0, 32'h0000_1003, 2'd0, 1'b1, 32'h0, 1'b1, 32'h0000_0080, 1'b0, 1'b0);
        ack_with(32'h80FF_FFFF);
        wait_response("ldb_u", 0);

        $display("[TB] signed half load from 0x1002 with a slow slave");
        apply_stimulus(1'b0, 32'h0000_1002, 2'd1, 1'b0, 32'h0, 1'b1, 32'hFFFF_8001, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check_output("ldh_hold_cyc", 32'(bus_if.cyc_o), 32'd1);
            check_output("ldh_hold_adr", bus_if.adr_o, 32'h0000_1000);
            check_output("ldh_hold_sel", 32'(bus_if.sel_o), 32'hC);
            tick();
        end
        ack_with(32'h8001_1234);
        wait_response("ldh_s", 2);

        $display("[TB] half store to 0x2002");
        apply_stimulus(1'b1, 32'h0000_2002, 2'd1, 1'b0, 32'h0000_BEEF, 1'b1, 32'h0, 1'b0, 1'b0);
        check_output("sth_adr", bus_if.adr_o, 32'h0000_2000);
        check_output("sth_sel", 32'(bus_if.sel_o), 32'hC);
        check_output("sth_dat", bus_if.dat_o, 32'hBEEF_0000);
        check_output("sth_we",  32'(bus_if.we_o), 32'd1);
        ack_with(32'hFFFF_FFFF);
        wait_response("sth", 0);

        $display("[TB] misaligned word load from 0x3001");
        apply_stimulus(1'b0, 32'h0000_3001, 2'd2, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
        check_output("mis_valid_n1", 32'(bus_if.rsp_valid_o), 32'd1);
        check_output("mis_flag_n1",  32'(bus_if.rsp_misaligned_o), 32'd1);
        check_output("mis_no_cyc",   32'(bus_if.cyc_o), 32'd0);
        wait_response("mis_w", 0);

        $display("[TB] dword access on a 32-bit bus");
        apply_stimulus(1'b0, 32'h0000_4000, 2'd3, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
        check_output("mis_d_no_cyc", 32'(bus_if.cyc_o), 32'd0);
        wait_response("mis_d", 0);

        $display("[TB] err and ack together");
        apply_stimulus(1'b0, 32'h0000_5000, 2'd2, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
        bus_if.dat_i = 32'h1234_5678;
        bus_if.err_i = 1'b1;
        bus_if.ack_i = 1'b1;
        tick();
        bus_if.err_i = 1'b0;
        bus_if.ack_i = 1'b0;
        check_output("err_cyc_drop", 32'(bus_if.cyc_o), 32'd0);
        wait_response("err", 0);

        $display("[TB] retry exhaustion");
        apply_stimulus(1'b0, 32'h0000_6004, 2'd2, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check_output("rty_cyc", 32'(bus_if.cyc_o), 32'd1);
            check_output("rty_adr", bus_if.adr_o, 32'h0000_6004);
            bus_if.rty_i = 1'b1;
            tick();
            bus_if.rty_i = 1'b0;
            if (k < 3) begin
                check_output("rty_gap", 32'(bus_if.cyc_o), 32'd0);
                check_output("rty_gap_no_rsp", 32'(bus_if.rsp_valid_o), 32'd0);
                tick();
            end
        end
        check_output("rty_end_cyc", 32'(bus_if.cyc_o), 32'd0);
        wait_response("rty_exh", 0);

        $display("[TB] three retries then ack on a fresh request");
        apply_stimulus(1'b0, 32'h0000_6008, 2'd2, 1'b0, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            bus_if.rty_i = 1'b1;
            tick();
            bus_if.rty_i = 1'b0;
            tick();
        end
        check_output("rty_ok_cyc", 32'(bus_if.cyc_o), 32'd1);
        ack_with(32'hCAFE_F00D);
        wait_response("rty_ok", 0);

`ifdef WB_LSU_TIMEOUT_EN
        $display("[TB] silent slave with watchdog");
        apply_stimulus(1'b0, 32'h0000_7000, 2'd2, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
        n = 0;
        while (bus_if.cyc_o === 1'b1 && n < 50) begin
            n++;
            tick();
        end
        check_output("tmo_len", 32'(n), 32'(TIMEOUT_CYCLES));
        wait_response("tmo", 0);

        $display("[TB] ack on the expiry cycle");
        apply_stimulus(1'b0, 32'h0000_7004, 2'd2, 1'b0, 32'h0, 1'b1, 32'h1122_3344, 1'b0, 1'b0);
        repeat (TIMEOUT_CYCLES - 1) tick();
        check_output("tmo_edge_cyc", 32'(bus_if.cyc_o), 32'd1);
        ack_with(32'h1122_3344);
        wait_response("tmo_edge", 0);

        apply_stimulus(1'b0, 32'h0000_7008, 2'd2, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (3) tick();
`else
        $display("[TB] silent slave without watchdog");
        apply_stimulus(1'b0, 32'h0000_7000, 2'd2, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (100) tick();
        check_output("no_tmo_cyc", 32'(bus_if.cyc_o), 32'd1);
`endif

        $display("[TB] reset in the middle of a bus cycle");
        check_output("rst_mid_busy", 32'(bus_if.cyc_o), 32'd1);
        bus_if.rsp_ready_i = 1'b1;
        rst_n = 1'b0;
        #1;
        check_output("rst_mid_cyc", 32'(bus_if.cyc_o), 32'd0);
        check_output("rst_mid_stb", 32'(bus_if.stb_o), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        n = 0;
        repeat (10) begin
            tick();
            if (bus_if.rsp_valid_o === 1'b1) n++;
        end
        check_output("rst_no_rsp", 32'(n), 32'd0);
        bus_if.rsp_ready_i = 1'b0;

        $display("[TB] normal load after reset");
        apply_stimulus(1'b0, 32'h0000_8000, 2'd2, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        check_output("post_rst_cyc", 32'(bus_if.cyc_o), 32'd1);
        check_output("post_rst_adr", bus_if.adr_o, 32'h0000_8000);
        ack_with(32'hDEAD_BEEF);
        wait_response("post_rst", 0);

        check_output("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_lsu.md
WB_LSU -- requirements
Module: wb_lsu

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data bus width; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 SHALL have parameter MAX_RETRY, default 3, meaning rty_i reissues permitted before the request fails.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning maximum wait for ack/err/rty per bus cycle.
REQ-005 SHALL have ports as follows; one clock; reset is asynchronous and active-low:
 clk_i  in  1  clock, all state on rising edge
 rst_ni  in  1  asynchronous active-low reset
 req_valid_i / req_ready_o  in/out  1  request handshake
 req_we_i  in  1  1 = store, 0 = load
 req_addr_i  in  ADDR_W  byte address
 req_size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (DATA_W=64 only)
 req_unsigned_i  in  1  zero-extend load result
 req_wdata_i  in  DATA_W  store data, right-aligned
 rsp_valid_o / rsp_ready_i  out/in  1  response handshake
 rsp_rdata_o  out  DATA_W  extended load data; 0 for stores
 rsp_err_o  out  1  bus error, retry exhaustion or timeout
 rsp_misaligned_o  out  1  misaligned access; no bus cycle issued
 cyc_o, stb_o, we_o  out  1  Wishbone classic master strobes
 adr_o  out  ADDR_W  word-aligned bus address
 sel_o  out  DATA_W/8  byte-lane select
 dat_o / dat_i  out/in  DATA_W  write/read data
 ack_i, err_i, rty_i  in  1  Wishbone cycle terminations

Function
REQ-006 SHALL implement states IDLE, BUS, GAP, RESP; req_ready_o = 1 only in IDLE.
REQ-007 SHALL capture the request on req_valid_i & req_ready_o (cycle N) and assert cyc_o/stb_o from cycle N+1; all bus outputs registered.
REQ-008 SHALL flag misaligned when addr mod (1<<size) != 0, or size=3 with DATA_W=32; IDLE->RESP with rsp_misaligned_o=1, rsp_err_o=0, no cyc_o, rsp_valid_o at N+1.
REQ-009 SHALL drive adr_o = addr with low log2(DATA_W/8) bits cleared, sel_o = size-mask shifted by the lane offset, dat_o = wdata shifted left by 8*lane offset.
REQ-010 SHALL hold cyc_o, stb_o, adr_o, sel_o, we_o, dat_o stable in BUS until a termination is sampled.
REQ-011 SHALL prioritise terminations err_i > ack_i > rty_i when sampled together.
REQ-012 On ack_i SHALL deassert cyc_o/stb_o next cycle, enter RESP, and for loads present dat_i lane extracted and sign/zero-extended to DATA_W.
REQ-013 On err_i SHALL enter RESP with rsp_err_o=1, rsp_rdata_o=0.
REQ-014 On rty_i with retry count < MAX_RETRY SHALL increment the count, enter GAP (cyc_o=0 for exactly one cycle), then reissue identical cycle in BUS; at count = MAX_RETRY SHALL enter RESP with rsp_err_o=1.
REQ-015 SHALL hold rsp_valid_o and all rsp_* stable in RESP until rsp_ready_i; RESP->IDLE on handshake; next request accepted one cycle later.
REQ-016 SHALL clear retry and timeout counters on every request acceptance.

Reset
REQ-017 SHALL, while rst_ni=0, force IDLE, cyc_o=stb_o=we_o=0, adr_o=sel_o=dat_o=0, rsp_valid_o=rsp_err_o=rsp_misaligned_o=0, rsp_rdata_o=0, counters 0, req_ready_o=0.
REQ-018 SHALL abandon any in-progress bus cycle or pending response on reset assertion, with no response delivered afterwards.

Configuration
REQ-019 SHALL compile a per-bus-cycle timeout counter when macro WB_LSU_TIMEOUT_EN is defined: after TIMEOUT_CYCLES cycles in BUS without termination, drop cyc_o and enter RESP with rsp_err_o=1; without the macro, BUS waits indefinitely and the counter is absent.
REQ-020 SHALL count the timeout from the first BUS cycle, restart it after each GAP, and let a termination sampled on the expiry cycle take precedence.

Verification
REQ-021 Load byte 0x1003 signed, DATA_W=32, dat_i=0x80FFFFFF on ack -> adr_o=0x1000, sel_o=4'b1000, rsp_rdata_o=0xFFFFFF80.
REQ-022 Store half 0x2002 data 0x0000BEEF -> adr_o=0x2000, sel_o=4'b1100, dat_o=0xBEEF0000, we_o=1, rsp_err_o=0.
REQ-023 Load word 0x3001 -> rsp_misaligned_o=1 at N+1, cyc_o never asserted.
REQ-024 MAX_RETRY=3, rty_i on four consecutive cycles -> four bus cycles, each separated by one cyc_o=0 cycle, then rsp_err_o=1.
REQ-025 WB_LSU_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, slave silent -> cyc_o drops after 8 BUS cycles, rsp_err_o=1; macro undefined -> cyc_o still high after 100 cycles.
REQ-026 rst_ni pulled low mid BUS with rsp_ready_i=1 -> cyc_o=0 immediately, no rsp_valid_o after release; next request completes normally.
